// File: rtl/axis_tg_pkg.sv
// Shared types and LFSR polynomials for the AXI-Stream traffic generator.
// Tap masks are for right-shifting Galois LFSRs (bit i set <=> x^(i+1)).
package axis_tg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SEND,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    DM_RANDOM,
    DM_FIXED,
    DM_RR,
    DM_NOSELF
  } dest_mode_t;

  // x^16+x^15+x^13+x^4+1
  localparam logic [15:0] LOAD_TAPS = 16'hD008;
  // x^64+x^63+x^61+x^60+1
  localparam logic [63:0] DEST_TAPS = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR; steps once per cycle while advance is high.
// A zero seed would lock up, so it is replaced by 1.
module lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED_NZ;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator: random injection, multi-flit packets,
// per-destination sequence numbers and injection timestamps.
module axis_traffic_gen
  import axis_tg_pkg::*;
#(
  parameter int          TDATA_WIDTH = 32,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          TID         = 0,
  parameter int          COUNT_WIDTH = 16,
  parameter int          MAX_PKT_LEN = 8,
  parameter logic [63:0] DEST_SEED   = 64'h1,
  parameter logic [15:0] LOAD_SEED   = 16'h1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [TDEST_WIDTH-1:0]      fixed_dest,
  input  logic [15:0]                 load,
  input  logic [COUNT_WIDTH-1:0]      num_packets,
  input  logic [$clog2(MAX_PKT_LEN):0] pkt_len,
  input  logic [TDATA_WIDTH/2-1:0]    ticks,
  output logic                        done,
  output logic                        busy,
  output logic [2**TDEST_WIDTH-1:0][COUNT_WIDTH-1:0] sent_packets,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  output logic [TDATA_WIDTH-1:0]      axis_out_tdata,
  output logic                        axis_out_tlast,
  output logic [TID_WIDTH-1:0]        axis_out_tid,
  output logic [TDEST_WIDTH-1:0]      axis_out_tdest
);

  localparam int HALF = TDATA_WIDTH / 2;
  localparam int ND   = 2 ** TDEST_WIDTH;
  localparam int LW   = $clog2(MAX_PKT_LEN) + 1;
  localparam int LB   = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [TDEST_WIDTH-1:0] SELF = TDEST_WIDTH'(TID);
  localparam logic [LW-1:0]          MAXL = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0]          ONE  = LW'(1);
  localparam logic [LW-1:0]          TWO  = LW'(2);
  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

  state_t state_q, state_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic tvalid_q, tvalid_d;
  logic tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [TDEST_WIDTH-1:0] rr_q, rr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [ND-1:0][COUNT_WIDTH-1:0] sent_q, sent_d;

  logic [15:0] lfsr;
  logic [63:0] dlfsr;
  logic hs, last_hs, inj, launch, lfsr_adv;
  logic [TDEST_WIDTH-1:0] rnd_dest, new_dest;
  logic [LW-1:0] new_len;
  logic unused_dlfsr;

  assign hs       = tvalid_q & axis_out_tready;
  assign last_hs  = hs & tlast_q;
  assign inj      = lfsr <= load;
  assign lfsr_adv = (state_q == GAP) | last_hs;
  assign rnd_dest = dlfsr[TDEST_WIDTH-1:0];
  assign unused_dlfsr = ^dlfsr;

  lfsr_galois #(
    .WIDTH(16), .TAPS(LOAD_TAPS), .SEED(LOAD_SEED)
  ) u_load_lfsr (
    .clk(clk), .rst_n(rst_n),
    .advance(lfsr_adv), .value(lfsr)
  );

  lfsr_galois #(
    .WIDTH(64), .TAPS(DEST_TAPS), .SEED(DEST_SEED)
  ) u_dest_lfsr (
    .clk(clk), .rst_n(rst_n),
    .advance(launch), .value(dlfsr)
  );

  always_comb begin
    unique case (dest_mode_t'(mode))
      DM_FIXED:  new_dest = fixed_dest;
      DM_RR:     new_dest = rr_q;
      DM_NOSELF: new_dest = (rnd_dest == SELF) ? SELF + 1'b1 : rnd_dest;
      default:   new_dest = rnd_dest;
    endcase
    if (pkt_len == '0) begin
      new_len = (MAX_PKT_LEN > 1)
              ? LW'(dlfsr[TDEST_WIDTH +: LB]) + 1'b1 : ONE;
    end else if (pkt_len > MAXL) begin
      new_len = MAXL;
    end else begin
      new_len = pkt_len;
    end
  end

  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tdest_d  = tdest_q;
    rem_d    = rem_q;
    total_d  = total_q;
    sent_d   = sent_q;
    rr_d     = rr_q;
    launch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GAP;
          total_d = '0;
          sent_d  = '0;
          rr_d    = '0;
        end
      end
      GAP: begin
        if (!start) state_d = IDLE;
        else if (total_q == num_packets) state_d = DONE;
        else if (inj) launch = 1'b1;
      end
      SEND: begin
        if (hs && !tlast_q) begin
          rem_d   = rem_q - 1'b1;
          tlast_d = (rem_q == TWO);
        end else if (hs) begin
          total_d = total_q + 1'b1;
          if (sent_q[tdest_q] != CMAX) begin
            sent_d[tdest_q] = sent_q[tdest_q] + 1'b1;
          end
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          // a dropped start still lets the packet finish, but ends the run
          if (!start) state_d = IDLE;
          else if (total_d == num_packets) state_d = DONE;
          else if (inj) launch = 1'b1;
          else state_d = GAP;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // sequence uses sent_d so a back-to-back packet sees its predecessor
    if (launch) begin
      state_d  = SEND;
      tvalid_d = 1'b1;
      tdest_d  = new_dest;
      rem_d    = new_len;
      tlast_d  = (new_len == ONE);
      tdata_d  = {ticks, HALF'(sent_d[new_dest])};
      if (dest_mode_t'(mode) == DM_RR) rr_d = rr_q + 1'b1;
    end
  end

  assign done_d = (state_d == DONE);
  assign busy_d = (state_d == GAP) || (state_d == SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tdest_q  <= '0;
      rr_q     <= '0;
      rem_q    <= '0;
      total_q  <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tdest_q  <= tdest_d;
      rr_q     <= rr_d;
      rem_q    <= rem_d;
      total_q  <= total_d;
      sent_q   <= sent_d;
    end
  end

  assign done            = done_q;
  assign busy            = busy_q;
  assign sent_packets    = sent_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tdest  = tdest_q;
  assign axis_out_tid    = TID_WIDTH'(TID);

endmodule

// File: doc/axis_traffic_gen.md
# axis_traffic_gen

Parametrised AXI-Stream traffic generator for NoC harnesses. It is the successor to the single-flit generator and adds multi-flit packets (fixed or random length), selectable destination modes and back-to-back injection. It sits on each mesh/torus endpoint ingress, driven by a shared `ticks` counter, and pairs with `axis_checker` at the egress. Each flit carries an injection timestamp and a per-destination sequence number, so latency and ordering can be checked.

## Interface
- `TDATA_WIDTH`, 32: flit data width; must be even, ≥ 2·(TDEST_WIDTH+1).
- `TDEST_WIDTH`, 2: destination field width.
- `TID_WIDTH`, 2: source ID field width.
- `TID`, 0: this endpoint's ID, driven on `axis_out_tid`.
- `COUNT_WIDTH`, 16: packet counter width.
- `MAX_PKT_LEN`, 8: maximum flits per packet; power of two, ≥ 1.
- `DEST_SEED`, 64'h1: destination/length LFSR seed; 0 is replaced by 1.
- `LOAD_SEED`, 16'h1: injection LFSR seed; 0 is replaced by 1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; high runs the generator, low returns it to idle.
- `mode`  in  2  destination mode: 0 random, 1 fixed, 2 round-robin, 3 random-excluding-self.
- `fixed_dest`  in  TDEST_WIDTH  destination used in mode 1.
- `load`  in  16  injection probability ≈ load/65536 per eligible cycle.
- `num_packets`  in  COUNT_WIDTH  number of packets to send per run.
- `pkt_len`  in  $clog2(MAX_PKT_LEN)+1  flits per packet; 0 = random 1..MAX_PKT_LEN; values > MAX are clamped to MAX.
- `ticks`  in  TDATA_WIDTH/2  global timestamp.
- `done`  out  1  run complete; sticky until `start` goes low.
- `busy`  out  1  high in GAP or SEND.
- `sent_packets`  out  [2**TDEST_WIDTH] × COUNT_WIDTH  completed packets per destination.
- `axis_out_tvalid`, `axis_out_tready`, `axis_out_tdata`, `axis_out_tlast`, `axis_out_tid`, `axis_out_tdest`: AXI-Stream master; widths 1, 1, TDATA_WIDTH, 1, TID_WIDTH, TDEST_WIDTH.

## Operation
- FSM states:
  - IDLE → GAP when `start` = 1; this transition clears every counter and the round-robin pointer.
  - GAP → SEND on an injection decision.
  - GAP → IDLE when `start` = 0.
  - GAP → DONE when total sent = `num_packets`; `num_packets` = 0 therefore reaches DONE one cycle after entering GAP.
  - SEND → GAP / SEND / DONE / IDLE on the tlast handshake.
  - DONE → IDLE when `start` = 0.
- Injection decision: 16-bit Galois LFSR (taps x^16+x^15+x^13+x^4+1) advances every cycle in GAP and on the tlast-handshake cycle. Inject when `lfsr <= load`:
  - `load` = 0 never injects;
  - `load` = 16'hFFFF always injects.
- Packet launch latches the following values, which stay fixed for the whole packet:
  - `tdest`, from the mode:
    - random: `dlfsr[TDEST_WIDTH-1:0]`;
    - fixed: `fixed_dest`;
    - round-robin: pointer, then pointer+1 mod 2**TDEST_WIDTH;
    - mode 3: a random value equal to `TID` becomes `TID`+1 mod 2**TDEST_WIDTH.
  - Length: `pkt_len`, or `dlfsr[TDEST_WIDTH +: log2(MAX_PKT_LEN)]+1` when `pkt_len` = 0.
  - Timestamp: current `ticks`.
  - Sequence: `sent_packets[tdest]`.
  - The 64-bit `dlfsr` (taps x^64+x^63+x^61+x^60+1) advances once per launch.
- `tdata` = {timestamp, sequence zero-extended/truncated to TDATA_WIDTH/2}; it is identical on every flit of a packet.
- `tlast` is high on the final flit only; a length-1 packet has `tlast` on its head flit.
- `sent_packets[tdest]` increments on the tlast handshake; counters saturate at all-ones.
- `start` falling during SEND: the current packet completes (never truncated), then the FSM goes to IDLE without `done`.

## Timing
- All outputs are registered. Reset values:
  - `done`, `busy`, `tvalid`, `tlast`, `tdata`, `tdest` = 0;
  - `tid` = TID;
  - counters = 0;
  - LFSRs = seeds.
- `start` sampled high at edge n → `busy` = 1 at n+1.
- Injection decision at edge k → `tvalid` = 1 at k+1.
- Once asserted, `tvalid` stays high and all payload is stable until `tready`.
- A flit transfers on each cycle with `tvalid && tready`; the next flit is presented the following cycle.
- Back-to-back packets: if the tlast handshake cycle also produces an injection decision and packets remain, `tvalid` stays high and the next head flit follows immediately, giving 100% throughput at `load` = FFFF.
- `done` rises the cycle after the final tlast handshake.
- `rst_n` low at any time immediately forces the reset values above, including mid-packet.

## Structure
- Package `axis_tg_pkg` holds:
  - `state_t` enum (IDLE, GAP, SEND, DONE);
  - `dest_mode_t` enum;
  - LFSR tap constants `LOAD_TAPS`, `DEST_TAPS`.
- Sub-module `lfsr_galois` (parameters WIDTH, TAPS, SEED; ports `clk`, `rst_n`, `advance`, `value`) is instantiated twice.

## Test plan
- Mode 1, `fixed_dest` = 2, `pkt_len` = 4, `load` = FFFF, `num_packets` = 3, `tready` = 1 → 12 consecutive flits, `tlast` on flits 4/8/12, `sent_packets` = {0,0,3,0}, `done` one cycle after the last flit.
- Mode 2, `pkt_len` = 1, `num_packets` = 8 → tdest sequence 0,1,2,3,0,1,2,3; tdata low half 0,0,0,0,1,1,1,1.
- Mode 3, TID = 1, `num_packets` = 1024 → tdest never equals 1; the sum of `sent_packets` = 1024.
- `tready` held low for 5 cycles mid-packet → `tvalid`, `tdata`, `tlast` and `tdest` stay constant; no flit is lost or duplicated.
- `load` = 0 → `tvalid` never asserts over 10,000 cycles. `load` = 16384 → injection rate 0.25 ± 0.02.
- `start` dropped on flit 2 of a 4-flit packet → flits 3 and 4 still transfer, then IDLE with `done` = 0. Async `rst_n` pulse mid-packet → outputs at reset values in the same cycle.
